// File: rtl/lcd_text_fmt_if.sv
// rtl/lcd_text_fmt_if.sv - request/reading/row bundle between the fishbowl sensors, lcd_text_fmt and the LCD driver
//
// Signals:
//   upd_req    update request (sampled every rising edge)
//   temp_data  DS18B20 reading, two's complement, LSB = 1/16 degC
//   level_pct  water level in percent, unsigned
//   busy       conversion in progress
//   rows_vld   one-cycle pulse when row_1/row_2 take new content
//   row_1      line 1 text, MSB byte = leftmost character
//   row_2      line 2 text, MSB byte = leftmost character
// Modports: master drives request and readings; slave (the formatter) drives status and rows.
interface lcd_text_fmt_if;
  logic         upd_req;
  logic [15:0]  temp_data;
  logic [6:0]   level_pct;
  logic         busy;
  logic         rows_vld;
  logic [127:0] row_1;
  logic [127:0] row_2;

  modport master (
    output upd_req, temp_data, level_pct,
    input  busy, rows_vld, row_1, row_2
  );

  modport slave (
    input  upd_req, temp_data, level_pct,
    output busy, rows_vld, row_1, row_2
  );
endinterface

// File: rtl/lcd_text_fmt.sv
// rtl/lcd_text_fmt.sv - temperature/level to two 16-character ASCII rows for the LCD1602 driver
//
// On request, captures the temperature and level readings. Converts both to BCD with an
// 8-cycle sequential double dabble. Loads row_1/row_2 in one step, so the driver never
// sees a half-written row.
// Optional feature macro: LCD_ALARM_EN (adds " LOW "/" HIGH" status in row_2 chars 12-16).
//
// Ports:
//   clk    system clock, 50 MHz
//   rst_n  asynchronous active-low reset
//   bus    lcd_text_fmt_if.slave: upd_req, temp_data, level_pct in; busy, rows_vld, row_1, row_2 out
module lcd_text_fmt #(
  parameter int LEVEL_LOW  = 20,
  parameter int LEVEL_HIGH = 90
) (
  input  logic          clk,
  input  logic          rst_n,
  lcd_text_fmt_if.slave bus
);

  localparam logic [127:0] ROW1_RST  = "TEMP:  ---.- C  ";
  localparam logic [127:0] ROW2_RST  = "LEVEL: ---%     ";
  localparam logic [47:0]  TEMP_PFX  = "TEMP: ";
  localparam logic [31:0]  TEMP_SFX  = " C  ";
  localparam logic [55:0]  LEVEL_PFX = "LEVEL: ";
  localparam logic [7:0]   CH_PLUS   = 8'h2B;
  localparam logic [7:0]   CH_MINUS  = 8'h2D;
  localparam logic [7:0]   CH_DOT    = 8'h2E;
  localparam logic [7:0]   CH_PCT    = 8'h25;
  localparam logic [39:0]  BLANK5    = "     ";

  typedef enum logic [1:0] {IDLE, CONV, PACK} state_t;

  state_t       state, state_next;
  logic [2:0]   shift_cnt;
  logic [19:0]  temp_dd;     // {hundreds, tens, ones, integer degC}
  logic [19:0]  level_dd;    // {hundreds, tens, ones, clamped level}
  logic         neg;
  logic         range_err;
  logic [3:0]   frac;
  logic [127:0] row_1_q, row_2_q;
  logic         rows_vld_q;
  logic [127:0] row_1_next, row_2_next;
  logic [39:0]  status;

  logic [15:0]  mag;
  logic [7:0]   level_clamp;
  logic [3:0]   frac_next;

  function automatic logic [19:0] dd_step(input logic [19:0] r);
    logic [19:0] a;
    a = r;
    if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
    if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
    if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Capture-side arithmetic on the live inputs.
  always_comb begin
    mag         = bus.temp_data[15] ? (~bus.temp_data + 16'd1) : bus.temp_data;
    level_clamp = (bus.level_pct > 7'd100) ? 8'd100 : {1'b0, bus.level_pct};
    // Tenths digit = floor(sixteenths * 10 / 16), tabulated.
    case (mag[3:0])
      4'd0, 4'd1:   frac_next = 4'd0;
      4'd2, 4'd3:   frac_next = 4'd1;
      4'd4:         frac_next = 4'd2;
      4'd5, 4'd6:   frac_next = 4'd3;
      4'd7:         frac_next = 4'd4;
      4'd8, 4'd9:   frac_next = 4'd5;
      4'd10, 4'd11: frac_next = 4'd6;
      4'd12:        frac_next = 4'd7;
      4'd13, 4'd14: frac_next = 4'd8;
      default:      frac_next = 4'd9;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.upd_req) state_next = CONV;
      CONV:    if (shift_cnt == 3'd7) state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LCD_ALARM_EN
  logic [7:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              level_q <= 8'd0;
    else if (state == IDLE && bus.upd_req)   level_q <= level_clamp;
  end

  always_comb begin
    status = BLANK5;
    if (level_q < 8'(LEVEL_LOW))       status = " LOW ";
    else if (level_q > 8'(LEVEL_HIGH)) status = " HIGH";
  end
`else
  // Thresholds only matter with the alarm field; keep them referenced without logic.
  localparam int unused_level_bounds = LEVEL_LOW + LEVEL_HIGH;

  always_comb begin
    status = BLANK5;
  end
`endif

  // Row images built from the finished BCD registers.
  always_comb begin
    row_1_next = ROW1_RST;
    if (!range_err) begin
      row_1_next = {TEMP_PFX, (neg ? CH_MINUS : CH_PLUS),
                    asc(temp_dd[19:16]), asc(temp_dd[15:12]), asc(temp_dd[11:8]),
                    CH_DOT, asc(frac), TEMP_SFX};
    end
    row_2_next = {LEVEL_PFX, asc(level_dd[19:16]), asc(level_dd[15:12]),
                  asc(level_dd[11:8]), CH_PCT, status};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_cnt  <= 3'd0;
      temp_dd    <= 20'd0;
      level_dd   <= 20'd0;
      neg        <= 1'b0;
      range_err  <= 1'b0;
      frac       <= 4'd0;
      row_1_q    <= ROW1_RST;
      row_2_q    <= ROW2_RST;
      rows_vld_q <= 1'b0;
    end else begin
      rows_vld_q <= (state == PACK);
      case (state)
        IDLE: begin
          if (bus.upd_req) begin
            shift_cnt <= 3'd0;
            temp_dd   <= {12'd0, mag[11:4]};
            level_dd  <= {12'd0, level_clamp};
            neg       <= bus.temp_data[15];
            range_err <= |mag[15:12];
            frac      <= frac_next;
          end
        end
        CONV: begin
          temp_dd   <= dd_step(temp_dd);
          level_dd  <= dd_step(level_dd);
          shift_cnt <= shift_cnt + 3'd1;
        end
        PACK: begin
          row_1_q <= row_1_next;
          row_2_q <= row_2_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.rows_vld = rows_vld_q;
  assign bus.row_1    = row_1_q;
  assign bus.row_2    = row_2_q;

endmodule
